// File: rtl/ibex_multdiv_arbiter.sv
// Round-robin arbiter that shares one ibex multdiv datapath between two requesters and can pad
// every operation to a fixed latency. The optional watchdog is enabled by IBEX_MDA_WATCHDOG_EN.
module ibex_multdiv_arbiter #(
  parameter int unsigned MUL_LAT     = 3,
  parameter int unsigned DIV_LAT     = 37
`ifdef IBEX_MDA_WATCHDOG_EN
  ,
  parameter int unsigned WDOG_CYCLES = 63
`endif
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             data_ind_timing_i,
  input  logic [1:0]       req_valid_i,
  output logic [1:0]       req_ready_o,
  input  logic [1:0][1:0]  req_op_i,
  input  logic [1:0][1:0]  req_signed_mode_i,
  input  logic [1:0][31:0] req_op_a_i,
  input  logic [1:0][31:0] req_op_b_i,
  output logic [1:0]       rsp_valid_o,
  input  logic [1:0]       rsp_ready_i,
  output logic [31:0]      rsp_result_o,
  output logic             rsp_err_o,
  output logic             mult_en_o,
  output logic             div_en_o,
  output logic             mult_sel_o,
  output logic             div_sel_o,
  output logic [1:0]       operator_o,
  output logic [1:0]       signed_mode_o,
  output logic [31:0]      op_a_o,
  output logic [31:0]      op_b_o,
  output logic             multdiv_ready_id_o,
  input  logic [31:0]      multdiv_result_i,
  input  logic             valid_i
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    PAD  = 2'd2,
    RESP = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    MD_OP_MULL = 2'd0,
    MD_OP_MULH = 2'd1,
    MD_OP_DIV  = 2'd2,
    MD_OP_REM  = 2'd3
  } md_op_e;

  // Everything captured at accept and held stable until the next accept.
  typedef struct packed {
    md_op_e      op;
    logic [1:0]  signed_mode;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        dit;
    logic        gnt;
  } ctx_t;

  localparam logic [5:0] MUL_LAT_C = 6'(MUL_LAT);
  localparam logic [5:0] DIV_LAT_C = 6'(DIV_LAT);
  localparam logic [5:0] CNT_MAX   = 6'd63;
`ifdef IBEX_MDA_WATCHDOG_EN
  localparam logic [5:0] WDOG_LAST = 6'(WDOG_CYCLES - 1);
`endif

  function automatic logic op_is_div(input md_op_e op);
    return (op == MD_OP_DIV) || (op == MD_OP_REM);
  endfunction

  function automatic logic [1:0] onehot(input logic idx);
    return idx ? 2'b10 : 2'b01;
  endfunction

  state_e      state_q, state_d;
  ctx_t        ctx_q, ctx_d;
  logic        prio_q, prio_d;
  logic [5:0]  cnt_q, cnt_d, cnt_inc;
  logic [31:0] res_q, res_d;
  logic        err_q, err_d;
  logic        mult_en_q, mult_en_d;
  logic        div_en_q, div_en_d;
  logic        mult_sel_q, mult_sel_d;
  logic        div_sel_q, div_sel_d;
  logic        rdy_id_q, rdy_id_d;
  logic [1:0]  rsp_valid_q, rsp_valid_d;
  logic        gnt_idx;
  logic        acc_is_div;
  logic [5:0]  lat;

  // A tie goes to the requester that was not served last.
  always_comb begin
    case (req_valid_i)
      2'b10:   gnt_idx = 1'b1;
      2'b11:   gnt_idx = prio_q;
      default: gnt_idx = 1'b0;
    endcase
  end

  assign acc_is_div = op_is_div(md_op_e'(req_op_i[gnt_idx]));
  assign lat        = op_is_div(ctx_q.op) ? DIV_LAT_C : MUL_LAT_C;
  assign cnt_inc    = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 6'd1;

  // NOTE: every signal assigned in this block gets a default first, so no path can leave a
  // variable unassigned and infer a latch.
  always_comb begin
    state_d     = state_q;
    ctx_d       = ctx_q;
    prio_d      = prio_q;
    cnt_d       = cnt_q;
    res_d       = res_q;
    err_d       = err_q;
    mult_en_d   = mult_en_q;
    div_en_d    = div_en_q;
    mult_sel_d  = mult_sel_q;
    div_sel_d   = div_sel_q;
    rdy_id_d    = rdy_id_q;
    rsp_valid_d = rsp_valid_q;
    req_ready_o = 2'b00;

    unique case (state_q)
      IDLE: begin
        if (|req_valid_i) begin
          req_ready_o       = onehot(gnt_idx);
          ctx_d.op          = md_op_e'(req_op_i[gnt_idx]);
          ctx_d.signed_mode = req_signed_mode_i[gnt_idx];
          ctx_d.op_a        = req_op_a_i[gnt_idx];
          ctx_d.op_b        = req_op_b_i[gnt_idx];
          ctx_d.dit         = data_ind_timing_i;
          ctx_d.gnt         = gnt_idx;
          prio_d            = ~gnt_idx;
          cnt_d             = '0;
          err_d             = 1'b0;
          mult_sel_d        = ~acc_is_div;
          div_sel_d         = acc_is_div;
          mult_en_d         = ~acc_is_div;
          div_en_d          = acc_is_div;
          rdy_id_d          = 1'b1;
          state_d           = BUSY;
        end
      end

      BUSY: begin
        cnt_d = cnt_inc;
        if (valid_i) begin
          // cnt_q + 1 BUSY cycles have elapsed; exceeding the budget is a timing error.
          res_d     = multdiv_result_i;
          err_d     = ctx_q.dit && (cnt_q >= lat);
          mult_en_d = 1'b0;
          div_en_d  = 1'b0;
          rdy_id_d  = 1'b0;
          state_d   = PAD;
        end
`ifdef IBEX_MDA_WATCHDOG_EN
        else if (cnt_q == WDOG_LAST) begin
          // Ready stays high into RESP so the datapath can drop back to idle.
          res_d       = '0;
          err_d       = 1'b1;
          mult_en_d   = 1'b0;
          div_en_d    = 1'b0;
          rsp_valid_d = onehot(ctx_q.gnt);
          state_d     = RESP;
        end
`endif
      end

      // Always visited once after capture; in DIT mode it holds until the latency budget.
      PAD: begin
        cnt_d = cnt_inc;
        if (!ctx_q.dit || (cnt_q >= lat)) begin
          rsp_valid_d = onehot(ctx_q.gnt);
          state_d     = RESP;
        end
      end

      RESP: begin
        rdy_id_d = 1'b0;
        if (rsp_ready_i[ctx_q.gnt]) begin
          rsp_valid_d = 2'b00;
          mult_sel_d  = 1'b0;
          div_sel_d   = 1'b0;
          state_d     = IDLE;
        end
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples the
  // pre-edge values; blocking here would create order-dependent simulation races.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      ctx_q       <= '0;
      prio_q      <= 1'b0;
      cnt_q       <= '0;
      res_q       <= '0;
      err_q       <= 1'b0;
      mult_en_q   <= 1'b0;
      div_en_q    <= 1'b0;
      mult_sel_q  <= 1'b0;
      div_sel_q   <= 1'b0;
      rdy_id_q    <= 1'b0;
      rsp_valid_q <= 2'b00;
    end else begin
      state_q     <= state_d;
      ctx_q       <= ctx_d;
      prio_q      <= prio_d;
      cnt_q       <= cnt_d;
      res_q       <= res_d;
      err_q       <= err_d;
      mult_en_q   <= mult_en_d;
      div_en_q    <= div_en_d;
      mult_sel_q  <= mult_sel_d;
      div_sel_q   <= div_sel_d;
      rdy_id_q    <= rdy_id_d;
      rsp_valid_q <= rsp_valid_d;
    end
  end

  assign rsp_valid_o        = rsp_valid_q;
  assign rsp_result_o       = res_q;
  assign rsp_err_o          = err_q;
  assign mult_en_o          = mult_en_q;
  assign div_en_o           = div_en_q;
  assign mult_sel_o         = mult_sel_q;
  assign div_sel_o          = div_sel_q;
  assign operator_o         = ctx_q.op;
  assign signed_mode_o      = ctx_q.signed_mode;
  assign op_a_o             = ctx_q.op_a;
  assign op_b_o             = ctx_q.op_b;
  assign multdiv_ready_id_o = rdy_id_q;

endmodule

// File: tb/tb_ibex_multdiv_arbiter.sv
// Self-checking bench for ibex_multdiv_arbiter: table of single operations, then hand-written
// arbitration, reset-abort and watchdog sequences. The bench plays the multdiv datapath.
module tb_ibex_multdiv_arbiter;

  logic             clk_i = 1'b0;
  logic             rst_ni = 1'b0;
  logic             data_ind_timing_i = 1'b0;
  logic [1:0]       req_valid_i = 2'b00;
  logic [1:0]       req_ready_o;
  logic [1:0][1:0]  req_op_i = '0;
  logic [1:0][1:0]  req_signed_mode_i = '0;
  logic [1:0][31:0] req_op_a_i = '0;
  logic [1:0][31:0] req_op_b_i = '0;
  logic [1:0]       rsp_valid_o;
  logic [1:0]       rsp_ready_i = 2'b00;
  logic [31:0]      rsp_result_o;
  logic             rsp_err_o;
  logic             mult_en_o, div_en_o, mult_sel_o, div_sel_o;
  logic [1:0]       operator_o, signed_mode_o;
  logic [31:0]      op_a_o, op_b_o;
  logic             multdiv_ready_id_o;
  logic [31:0]      multdiv_result_i = '0;
  logic             valid_i = 1'b0;

  int checks = 0;
  int errors = 0;

  ibex_multdiv_arbiter dut (
    .clk_i             (clk_i),
    .rst_ni            (rst_ni),
    .data_ind_timing_i (data_ind_timing_i),
    .req_valid_i       (req_valid_i),
    .req_ready_o       (req_ready_o),
    .req_op_i          (req_op_i),
    .req_signed_mode_i (req_signed_mode_i),
    .req_op_a_i        (req_op_a_i),
    .req_op_b_i        (req_op_b_i),
    .rsp_valid_o       (rsp_valid_o),
    .rsp_ready_i       (rsp_ready_i),
    .rsp_result_o      (rsp_result_o),
    .rsp_err_o         (rsp_err_o),
    .mult_en_o         (mult_en_o),
    .div_en_o          (div_en_o),
    .mult_sel_o        (mult_sel_o),
    .div_sel_o         (div_sel_o),
    .operator_o        (operator_o),
    .signed_mode_o     (signed_mode_o),
    .op_a_o            (op_a_o),
    .op_b_o            (op_b_o),
    .multdiv_ready_id_o(multdiv_ready_id_o),
    .multdiv_result_i  (multdiv_result_i),
    .valid_i           (valid_i)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic        req;
    logic [1:0]  op;
    logic [1:0]  sm;
    logic [31:0] a;
    logic [31:0] b;
    logic        dit;
    int          dly;   // BUSY cycle in which the datapath raises valid_i
    logic [31:0] res;
    logic        err;
    int          lat;   // accept edge to rsp_valid_o edge
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic req, input logic [1:0] op, input logic [1:0] sm,
                              input logic [31:0] a, input logic [31:0] b, input logic dit,
                              input int dly, input logic [31:0] res, input logic err,
                              input int lat);
    vec_t v;
    v.req = req; v.op = op; v.sm = sm; v.a = a; v.b = b; v.dit = dit;
    v.dly = dly; v.res = res; v.err = err; v.lat = lat;
    return v;
  endfunction

  // Behavioural multdiv: computes from the operands the arbiter presents.
  function automatic logic [31:0] dp_model(input logic [1:0] op, input logic [1:0] sm,
                                           input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sp;
    logic        [63:0] up;
    logic signed [31:0] sa, sb;
    sa = a;
    sb = b;
    case (op)
      2'd0: return a * b;
      2'd1: begin
        if (sm == 2'b11) begin
          sp = 64'(sa) * 64'(sb);
          return sp[63:32];
        end
        up = {32'b0, a} * {32'b0, b};
        return up[63:32];
      end
      2'd2: begin
        if (b == 0) return 32'hFFFF_FFFF;
        return (sm == 2'b11) ? 32'(sa / sb) : a / b;
      end
      default: begin
        if (b == 0) return a;
        return (sm == 2'b11) ? 32'(sa % sb) : a % b;
      end
    endcase
  endfunction

  task automatic tick();
    @(posedge clk_i);
    #2;
  endtask

  task automatic run_vec(input string tag, input vec_t v);
    logic [1:0] oh;
    logic [1:0] sel;
    int         lat;
    oh  = v.req ? 2'b10 : 2'b01;
    sel = v.op[1] ? 2'b01 : 2'b10;
    req_op_i[v.req]          = v.op;
    req_signed_mode_i[v.req] = v.sm;
    req_op_a_i[v.req]        = v.a;
    req_op_b_i[v.req]        = v.b;
    data_ind_timing_i        = v.dit;
    req_valid_i              = oh;
    #1;
    check({tag, " ready"}, 32'(req_ready_o), 32'(oh));
    tick();
    req_valid_i       = 2'b00;
    data_ind_timing_i = ~v.dit;
    check({tag, " sel"}, 32'({mult_sel_o, div_sel_o}), 32'(sel));
    check({tag, " opcode"}, 32'({operator_o, signed_mode_o}), 32'({v.op, v.sm}));
    check({tag, " op_a"}, op_a_o, v.a);
    check({tag, " op_b"}, op_b_o, v.b);
    lat = -1;
    for (int k = 1; k <= 200; k++) begin
      if (rsp_valid_o != 2'b00) begin
        lat = k - 1;
        break;
      end
      if (k == 1) begin
        check({tag, " en busy"}, 32'({mult_en_o, div_en_o}), 32'(sel));
        check({tag, " ready_id busy"}, 32'(multdiv_ready_id_o), 32'd1);
      end
      if (k == v.dly + 1)
        check({tag, " en dropped"}, 32'({mult_en_o, div_en_o}), 32'd0);
      valid_i          = (k == v.dly);
      multdiv_result_i = (k == v.dly) ? dp_model(operator_o, signed_mode_o, op_a_o, op_b_o)
                                      : 32'hDEAD_BEEF;
      tick();
    end
    valid_i           = 1'b0;
    data_ind_timing_i = 1'b0;
    check({tag, " latency"}, 32'(lat), 32'(v.lat));
    check({tag, " rsp_valid"}, 32'(rsp_valid_o), 32'(oh));
    check({tag, " result"}, rsp_result_o, v.res);
    check({tag, " err"}, 32'(rsp_err_o), 32'(v.err));
    check({tag, " sel held"}, 32'({mult_sel_o, div_sel_o}), 32'(sel));
    rsp_ready_i = oh;
    tick();
    rsp_ready_i = 2'b00;
    check({tag, " rsp released"}, 32'(rsp_valid_o), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL global timeout");
    $fatal(1, "simulation did not finish");
  end

  initial begin
    logic [1:0] exp_gnt;
    int         lat;

    // req, op, sm, a, b, dit, dly, res, err, lat
    vecs[0] = mk(1'b0, 2'd0, 2'b00, 32'd7,          32'd6,  1'b0, 2,  32'd42,         1'b0, 3);
    vecs[1] = mk(1'b1, 2'd2, 2'b00, 32'd100,        32'd0,  1'b1, 1,  32'hFFFF_FFFF,  1'b0, 38);
    vecs[2] = mk(1'b0, 2'd1, 2'b00, 32'h8000_0000,  32'd4,  1'b1, 5,  32'd2,          1'b1, 6);
    vecs[3] = mk(1'b1, 2'd3, 2'b00, 32'd100,        32'd7,  1'b0, 4,  32'd2,          1'b0, 5);
    vecs[4] = mk(1'b0, 2'd0, 2'b00, 32'hFFFF_FFFF,  32'd2,  1'b1, 3,  32'hFFFF_FFFE,  1'b0, 4);
    vecs[5] = mk(1'b1, 2'd2, 2'b11, 32'hFFFF_FFEC,  32'd3,  1'b0, 1,  32'hFFFF_FFFA,  1'b0, 2);
    vecs[6] = mk(1'b0, 2'd2, 2'b00, 32'd1000,       32'd10, 1'b1, 37, 32'd100,        1'b0, 38);
    vecs[7] = mk(1'b1, 2'd2, 2'b00, 32'd9,          32'd2,  1'b1, 38, 32'd4,          1'b1, 39);

    #12;
    check("reset ctrl", 32'({req_ready_o, rsp_valid_o, rsp_err_o, mult_en_o, div_en_o,
                             mult_sel_o, div_sel_o, multdiv_ready_id_o, operator_o,
                             signed_mode_o}), 32'd0);
    check("reset data", op_a_o | op_b_o | rsp_result_o, 32'd0);
    rst_ni = 1'b1;
    tick();

    for (int i = 0; i < 8; i++) run_vec($sformatf("vec%0d", i), vecs[i]);

    // Both requesters pending: grants alternate and RESP blocks new grants until acknowledged.
    req_op_i          = '0;
    req_signed_mode_i = '0;
    req_op_a_i[0] = 32'd2; req_op_b_i[0] = 32'd3;
    req_op_a_i[1] = 32'd4; req_op_b_i[1] = 32'd5;
    req_valid_i = 2'b11;
    exp_gnt     = 2'b01;
    for (int n = 0; n < 4; n++) begin
      #1;
      check($sformatf("arb%0d grant", n), 32'(req_ready_o), 32'(exp_gnt));
      tick();
      check($sformatf("arb%0d busy ready", n), 32'(req_ready_o), 32'd0);
      valid_i          = 1'b1;
      multdiv_result_i = dp_model(operator_o, signed_mode_o, op_a_o, op_b_o);
      tick();
      valid_i = 1'b0;
      tick();
      check($sformatf("arb%0d rsp_valid", n), 32'(rsp_valid_o), 32'(exp_gnt));
      check($sformatf("arb%0d result", n), rsp_result_o, exp_gnt[0] ? 32'd6 : 32'd20);
      tick();
      check($sformatf("arb%0d resp hold", n), 32'({req_ready_o, rsp_valid_o}),
            32'({2'b00, exp_gnt}));
      rsp_ready_i = exp_gnt;
      tick();
      rsp_ready_i = 2'b00;
      exp_gnt     = {exp_gnt[0], exp_gnt[1]};
    end
    req_valid_i = 2'b00;
    #1;
    check("arb idle", 32'(req_ready_o), 32'd0);

    // Reset in BUSY cycle 10 of a divide aborts it.
    req_op_i[0] = 2'd2; req_op_a_i[0] = 32'd50; req_op_b_i[0] = 32'd5;
    req_valid_i = 2'b01;
    tick();
    req_valid_i = 2'b00;
    repeat (9) tick();
    check("pre-reset div_en", 32'(div_en_o), 32'd1);
    #1 rst_ni = 1'b0;
    #1;
    check("abort ctrl", 32'({req_ready_o, rsp_valid_o, rsp_err_o, mult_en_o, div_en_o,
                             mult_sel_o, div_sel_o, multdiv_ready_id_o, operator_o,
                             signed_mode_o}), 32'd0);
    check("abort data", op_a_o | op_b_o | rsp_result_o, 32'd0);
    tick();
    rst_ni = 1'b1;
    tick();
    tick();
    check("abort no rsp", 32'(rsp_valid_o), 32'd0);
    run_vec("post-reset", mk(1'b1, 2'd0, 2'b00, 32'd3, 32'd5, 1'b0, 1, 32'd15, 1'b0, 2));

`ifdef IBEX_MDA_WATCHDOG_EN
    req_op_i[0] = 2'd0; req_op_a_i[0] = 32'd9; req_op_b_i[0] = 32'd9;
    req_valid_i = 2'b01;
    tick();
    req_valid_i = 2'b00;
    lat = -1;
    for (int k = 1; k <= 100; k++) begin
      if (rsp_valid_o != 2'b00) begin
        lat = k - 1;
        break;
      end
      multdiv_result_i = 32'hDEAD_BEEF;
      tick();
    end
    check("wdog latency", 32'(lat), 32'd63);
    check("wdog rsp", 32'({rsp_valid_o, rsp_err_o, mult_en_o, multdiv_ready_id_o}),
          32'({2'b01, 1'b1, 1'b0, 1'b1}));
    check("wdog result", rsp_result_o, 32'd0);
    tick();
    check("wdog ready_id released", 32'({rsp_valid_o, multdiv_ready_id_o}), 32'({2'b01, 1'b0}));
    rsp_ready_i = 2'b01;
    tick();
    rsp_ready_i = 2'b00;
    check("wdog released", 32'(rsp_valid_o), 32'd0);
`else
    lat = 81;
    run_vec("long busy", mk(1'b0, 2'd0, 2'b00, 32'd9, 32'd9, 1'b0, 80, 32'd81, 1'b0, lat));
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
